// File: rtl/graphics_pkg.sv
// Shared types and canvas/spritesheet constants for the graphics pipeline.
// Holds the sprite table entry layout and the scheduler state encoding.
package graphics_pkg;

  localparam int CANVAS_WIDTH  = 360;
  localparam int CANVAS_HEIGHT = 720;
  localparam int NUM_FRAMES    = 18;

  localparam int X_W   = $clog2(CANVAS_WIDTH);
  localparam int Y_W   = $clog2(CANVAS_HEIGHT);
  localparam int F_W   = $clog2(NUM_FRAMES);
  localparam int LEN_W = 3;

  typedef struct packed {
    logic             active;
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [F_W-1:0]   base;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] phase;
  } sprite_entry_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_SCAN,
    S_ISSUE,
    S_HOLD,
    S_WAIT,
    S_DONE
  } sched_state_t;

  // An animation length of 0 behaves like 1, so the phase stays pinned at 0.
  function automatic logic [LEN_W-1:0] next_phase(input logic [LEN_W-1:0] phase,
                                                  input logic [LEN_W-1:0] len);
    logic [LEN_W-1:0] last;
    last = (len == '0) ? '0 : len - 1'b1;
    return (phase == last) ? '0 : phase + 1'b1;
  endfunction

endpackage

// File: rtl/sprite_slot_table.sv
// Register array of sprite entries with one write port, one combinational
// read port and a phase-advance port; a write overrides a same-slot advance.
module sprite_slot_table
  import graphics_pkg::*;
#(
  parameter  int MAX_SPRITES = 16,
  localparam int SLOT_W      = $clog2(MAX_SPRITES)
) (
  input  logic              clk_pixel,
  input  logic              sys_rst,
  input  logic              wr_en,
  input  logic [SLOT_W-1:0] wr_slot,
  input  sprite_entry_t     wr_entry,
  input  logic [SLOT_W-1:0] rd_slot,
  output sprite_entry_t     rd_entry,
  input  logic              adv_en,
  input  logic [SLOT_W-1:0] adv_slot
);

  sprite_entry_t table_q [MAX_SPRITES];
  sprite_entry_t table_d [MAX_SPRITES];

  assign rd_entry = table_q[rd_slot];

  always_comb begin
    for (int i = 0; i < MAX_SPRITES; i++) begin
      table_d[i] = table_q[i];
      if (adv_en && adv_slot == SLOT_W'(i)) begin
        table_d[i].phase = next_phase(table_q[i].phase, table_q[i].len);
      end
      if (wr_en && wr_slot == SLOT_W'(i)) begin
        table_d[i]       = wr_entry;
        table_d[i].phase = '0;
      end
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (!sys_rst) begin
      for (int i = 0; i < MAX_SPRITES; i++) begin
        table_q[i] <= '0;
      end
    end else begin
      table_q <= table_d;
    end
  end

endmodule

// File: rtl/sprite_scheduler.sv
// Per-frame scan of the sprite table, issuing one draw request at a time to the
// frame-composition block over a valid/ready handshake.
module sprite_scheduler #(
  parameter  int MAX_SPRITES   = 16,
  parameter  int CANVAS_WIDTH  = graphics_pkg::CANVAS_WIDTH,
  parameter  int CANVAS_HEIGHT = graphics_pkg::CANVAS_HEIGHT,
  parameter  int NUM_FRAMES    = graphics_pkg::NUM_FRAMES,
  parameter  int ANIM_SHIFT    = 2,
  localparam int SLOT_W        = $clog2(MAX_SPRITES),
  localparam int XW            = $clog2(CANVAS_WIDTH),
  localparam int YW            = $clog2(CANVAS_HEIGHT),
  localparam int FW            = $clog2(NUM_FRAMES)
) (
  input  logic              clk_pixel,
  input  logic              sys_rst,
  input  logic [5:0]        frame_count,
  input  logic              wr_en,
  input  logic [SLOT_W-1:0] wr_slot,
  input  logic              wr_active,
  input  logic [XW-1:0]     wr_x,
  input  logic [YW-1:0]     wr_y,
  input  logic [FW-1:0]     wr_base_frame,
  input  logic [2:0]        wr_anim_len,
  input  logic              sprite_ready,
  output logic              sprite_valid,
  output logic [XW-1:0]     sprite_x,
  output logic [YW-1:0]     sprite_y,
  output logic [FW-1:0]     sprite_frame_number,
  output logic              busy,
  output logic              frame_done,
  output logic              overrun
);
  import graphics_pkg::*;

  localparam int         SUM_W     = FW + 1;
  localparam logic [5:0] ANIM_MASK = 6'((1 << ANIM_SHIFT) - 1);

  sched_state_t      state_q, state_d;
  logic [SLOT_W-1:0] ptr_q, ptr_d;
  logic [5:0]        prev_frame_q, prev_frame_d;
  logic              anim_q, anim_d;
  logic              abort_pend_q, abort_pend_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              overrun_q, overrun_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [FW-1:0]     frame_q, frame_d;

  sprite_entry_t     rd_entry, wr_entry;
  logic              adv_en;
  logic              new_frame, anim_tick, last_slot;
  logic [SUM_W-1:0]  frame_sum;
  logic [FW-1:0]     frame_num;

  assign new_frame = (frame_count != prev_frame_q);
  assign anim_tick = new_frame && ((frame_count & ANIM_MASK) == '0);
  assign last_slot = (ptr_q == SLOT_W'(MAX_SPRITES - 1));

  // Saturate to the base frame rather than spilling into the next sprite's frames.
  assign frame_sum = {1'b0, rd_entry.base} + SUM_W'(rd_entry.phase);
  assign frame_num = (frame_sum >= SUM_W'(NUM_FRAMES)) ? rd_entry.base : frame_sum[FW-1:0];

  assign wr_entry = '{active: wr_active, x: wr_x, y: wr_y, base: wr_base_frame,
                      len: wr_anim_len, phase: '0};

  sprite_slot_table #(.MAX_SPRITES(MAX_SPRITES)) u_table (
    .clk_pixel (clk_pixel),
    .sys_rst   (sys_rst),
    .wr_en     (wr_en),
    .wr_slot   (wr_slot),
    .wr_entry  (wr_entry),
    .rd_slot   (ptr_q),
    .rd_entry  (rd_entry),
    .adv_en    (adv_en),
    .adv_slot  (ptr_q)
  );

  always_ff @(posedge clk_pixel) begin
    if (!sys_rst) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      prev_frame_q <= frame_count;
      anim_q       <= 1'b0;
      abort_pend_q <= 1'b0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      overrun_q    <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      frame_q      <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      prev_frame_q <= prev_frame_d;
      anim_q       <= anim_d;
      abort_pend_q <= abort_pend_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      overrun_q    <= overrun_d;
      x_q          <= x_d;
      y_q          <= y_d;
      frame_q      <= frame_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    anim_d       = anim_q;
    abort_pend_d = abort_pend_q;
    prev_frame_d = frame_count;
    case (state_q)
      S_IDLE, S_ARM, S_DONE: begin
        if (new_frame) begin
          state_d = S_ARM;
          ptr_d   = '0;
          anim_d  = anim_tick;
        end else if (state_q == S_ARM) begin
          state_d = S_SCAN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SCAN: begin
        if (new_frame) begin
          state_d = S_ARM;
          ptr_d   = '0;
          anim_d  = anim_tick;
        end else if (rd_entry.active) begin
          state_d = sprite_ready ? S_HOLD : S_ISSUE;
        end else if (last_slot) begin
          state_d = S_DONE;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      S_ISSUE: begin
        if (new_frame) begin
          state_d = S_ARM;
          ptr_d   = '0;
          anim_d  = anim_tick;
        end else if (sprite_ready) begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        state_d = S_WAIT;
        if (new_frame) begin
          abort_pend_d = 1'b1;
          anim_d       = anim_tick;
        end
      end
      S_WAIT: begin
        if (new_frame) begin
          abort_pend_d = 1'b1;
          anim_d       = anim_tick;
        end
        // An abort seen during the in-flight copy restarts only once ready returns.
        if (sprite_ready) begin
          if (abort_pend_q || new_frame) begin
            state_d      = S_ARM;
            ptr_d        = '0;
            abort_pend_d = 1'b0;
          end else if (last_slot) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SCAN;
            ptr_d   = ptr_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    valid_d   = ((state_q == S_SCAN) && !new_frame && rd_entry.active && sprite_ready) ||
                ((state_q == S_ISSUE) && !new_frame && sprite_ready);
    adv_en    = valid_d && anim_q;
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
    overrun_d = overrun_q || (new_frame && (state_q != S_IDLE) && (state_q != S_DONE));
    x_d       = x_q;
    y_d       = y_q;
    frame_d   = frame_q;
    if ((state_q == S_SCAN) && !new_frame && rd_entry.active) begin
      x_d     = rd_entry.x;
      y_d     = rd_entry.y;
      frame_d = frame_num;
    end
  end

  assign sprite_valid        = valid_q;
  assign sprite_x            = x_q;
  assign sprite_y            = y_q;
  assign sprite_frame_number = frame_q;
  assign busy                = busy_q;
  assign frame_done          = done_q;
  assign overrun             = overrun_q;

endmodule

// File: tb/tb_sprite_scheduler.sv
// Directed bench for sprite_scheduler with a ready model that mimics the
// composition block's registered busy period after each request.
module tb_sprite_scheduler;

  logic       clk_pixel = 1'b0;
  logic       sys_rst = 1'b0;
  logic [5:0] frame_count = '0;
  logic       wr_en = 1'b0;
  logic [3:0] wr_slot = '0;
  logic       wr_active = 1'b0;
  logic [8:0] wr_x = '0;
  logic [9:0] wr_y = '0;
  logic [4:0] wr_base_frame = '0;
  logic [2:0] wr_anim_len = '0;
  logic       sprite_ready = 1'b1;
  logic       sprite_valid;
  logic [8:0] sprite_x;
  logic [9:0] sprite_y;
  logic [4:0] sprite_frame_number;
  logic       busy;
  logic       frame_done;
  logic       overrun;

  int errors = 0;
  int checks = 0;
  int busy_time = 8;
  int busy_cnt = 0;
  int proto_err = 0;

  typedef struct packed {
    logic [8:0] x;
    logic [9:0] y;
    logic [4:0] f;
  } rec_t;
  rec_t vq[$];

  sprite_scheduler #(.ANIM_SHIFT(0)) dut (
    .clk_pixel           (clk_pixel),
    .sys_rst             (sys_rst),
    .frame_count         (frame_count),
    .wr_en               (wr_en),
    .wr_slot             (wr_slot),
    .wr_active           (wr_active),
    .wr_x                (wr_x),
    .wr_y                (wr_y),
    .wr_base_frame       (wr_base_frame),
    .wr_anim_len         (wr_anim_len),
    .sprite_ready        (sprite_ready),
    .sprite_valid        (sprite_valid),
    .sprite_x            (sprite_x),
    .sprite_y            (sprite_y),
    .sprite_frame_number (sprite_frame_number),
    .busy                (busy),
    .frame_done          (frame_done),
    .overrun             (overrun)
  );

  always #5 clk_pixel = ~clk_pixel;

  // Ready drops one edge after a request and returns busy_time edges later.
  always @(posedge clk_pixel) begin
    if (sprite_valid) begin
      sprite_ready <= 1'b0;
      busy_cnt     <= busy_time;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) sprite_ready <= 1'b1;
    end
  end

  always @(negedge clk_pixel) begin
    if (sys_rst && sprite_valid) begin
      vq.push_back('{x: sprite_x, y: sprite_y, f: sprite_frame_number});
      $display("issue #%0d x=%0d y=%0d frame=%0d ready=%0b", vq.size(), sprite_x, sprite_y,
               sprite_frame_number, sprite_ready);
      if (!sprite_ready) proto_err = proto_err + 1;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout required=finish errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_pixel);
  endtask

  task automatic write_slot(input int slot, input bit act, input int x, input int y,
                            input int base, input int len);
    wr_en         = 1'b1;
    wr_slot       = 4'(slot);
    wr_active     = act;
    wr_x          = 9'(x);
    wr_y          = 10'(y);
    wr_base_frame = 5'(base);
    wr_anim_len   = 3'(len);
    step(1);
    wr_en = 1'b0;
  endtask

  task automatic next_frame();
    frame_count = frame_count + 6'd1;
  endtask

  task automatic wait_done(input string tag, input int lim);
    int n = 0;
    while (frame_done !== 1'b1 && n < lim) begin
      step(1);
      n++;
    end
    chk(tag, int'(frame_done), 1);
    step(1);
  endtask

  task automatic wait_issues(input string tag, input int cnt, input int lim);
    int n = 0;
    while (vq.size() < cnt && n < lim) begin
      step(1);
      n++;
    end
    chk(tag, int'(vq.size() >= cnt), 1);
  endtask

  int exp_anim[5] = '{4, 5, 6, 4, 5};
  int exp_sat[4]  = '{16, 17, 16, 16};

  initial begin
    // Reset state
    step(3);
    chk("rst_valid", int'(sprite_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(frame_done), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_x", int'(sprite_x), 0);
    chk("rst_y", int'(sprite_y), 0);
    chk("rst_frame", int'(sprite_frame_number), 0);
    sys_rst = 1'b1;
    step(4);
    chk("no_spurious_busy", int'(busy), 0);
    chk("no_spurious_issue", vq.size(), 0);

    // Two active slots, slow ready
    busy_time = 4096;
    write_slot(0, 1, 10, 20, 2, 1);
    write_slot(3, 1, 100, 600, 5, 1);
    next_frame();
    step(1);
    chk("busy_after_detect", int'(busy), 1);
    step(1);
    chk("no_valid_in_arm", int'(sprite_valid), 0);
    step(1);
    chk("latency_valid", int'(sprite_valid), 1);
    chk("latency_x", int'(sprite_x), 10);
    wait_done("t1_done", 10000);
    chk("t1_count", vq.size(), 2);
    chk("t1_x0", int'(vq[0].x), 10);
    chk("t1_y0", int'(vq[0].y), 20);
    chk("t1_f0", int'(vq[0].f), 2);
    chk("t1_x1", int'(vq[1].x), 100);
    chk("t1_y1", int'(vq[1].y), 600);
    chk("t1_f1", int'(vq[1].f), 5);
    chk("t1_idle_busy", int'(busy), 0);
    chk("t1_hold_x", int'(sprite_x), 100);

    // Animation phase stepping, len 3
    busy_time = 4;
    write_slot(3, 0, 0, 0, 0, 0);
    write_slot(0, 1, 50, 60, 4, 3);
    vq.delete();
    for (int k = 0; k < 5; k++) begin
      next_frame();
      wait_done("t2_done", 200);
      chk($sformatf("t2_frame%0d", k), int'(vq[vq.size()-1].f), exp_anim[k]);
    end
    chk("t2_count", vq.size(), 5);

    // Saturation near the end of the spritesheet
    write_slot(0, 1, 7, 8, 16, 4);
    vq.delete();
    for (int k = 0; k < 4; k++) begin
      next_frame();
      wait_done("t3_done", 200);
      chk($sformatf("t3_frame%0d", k), int'(vq[vq.size()-1].f), exp_sat[k]);
    end

    // Overrun: new frame after the third issue
    chk("t4_overrun_clear", int'(overrun), 0);
    busy_time = 6;
    for (int i = 0; i < 16; i++) write_slot(i, 1, i * 10 + 1, i * 20 + 3, i, 1);
    vq.delete();
    next_frame();
    wait_issues("t4_third", 3, 500);
    next_frame();
    wait_done("t4_done", 2000);
    chk("t4_overrun", int'(overrun), 1);
    chk("t4_count", vq.size(), 19);
    chk("t4_third_x", int'(vq[2].x), 21);
    chk("t4_restart_x", int'(vq[3].x), 1);
    chk("t4_restart_f", int'(vq[3].f), 0);
    chk("t4_last_x", int'(vq[18].x), 151);
    chk("t4_protocol", proto_err, 0);

    // Slot 1 deactivated while the scan is still on slot 0
    vq.delete();
    next_frame();
    wait_issues("t5_first", 1, 100);
    write_slot(1, 0, 0, 0, 0, 0);
    wait_done("t5_done", 1000);
    chk("t5_count", vq.size(), 15);
    chk("t5_first_x", int'(vq[0].x), 1);
    chk("t5_skip_x", int'(vq[1].x), 21);
    chk("t5_skip_y", int'(vq[1].y), 43);
    chk("t5_last_x", int'(vq[14].x), 151);

    // Reset while waiting on ready
    write_slot(1, 1, 11, 23, 1, 1);
    vq.delete();
    next_frame();
    wait_issues("t6_first", 1, 100);
    step(2);
    sys_rst = 1'b0;
    step(1);
    chk("t6_rst_valid", int'(sprite_valid), 0);
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_x", int'(sprite_x), 0);
    chk("t6_rst_y", int'(sprite_y), 0);
    chk("t6_rst_frame", int'(sprite_frame_number), 0);
    chk("t6_rst_overrun", int'(overrun), 0);
    sys_rst = 1'b1;
    step(30);
    chk("t6_no_issue", vq.size(), 1);
    chk("t6_idle", int'(busy), 0);
    next_frame();
    wait_done("t6_empty_done", 100);
    chk("t6_table_cleared", vq.size(), 1);
    chk("t6_protocol", proto_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
